// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: adds two W-bit operands one 4-bit nibble per clock, LSB nibble first.
// Ports: clk, rst_n (async active-low); in_valid/in_ready accept a, b, carry_in;
// out_valid/out_ready hand off sum, carry_out, overflow.
// Macro NIBBLE_SERIAL_ADDER_OVERFLOW_EN compiles in the signed overflow detector;
// without it overflow is tied to 0.
module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 carry_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 carry_out,
  output logic                 overflow
);
  localparam int W  = 4 * NIBBLES;
  localparam int KW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
  state_t state, state_nx;
  logic [W-1:0] a_q, b_q;
  logic c_q;
  logic [KW-1:0] k;
  logic [4:0] nib;
  logic last;
  assign nib       = {1'b0, a_q[4*k +: 4]} + {1'b0, b_q[4*k +: 4]} + {4'd0, c_q};
  assign last      = k == KW'(NIBBLES - 1);
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  always_comb begin
    state_nx = state;
    if (state == IDLE && in_valid)       state_nx = ADD;
    else if (state == ADD && last)       state_nx = DONE;
    else if (state == DONE && out_ready) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= 1'b0;
      k         <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
    end else if (in_ready && in_valid) begin
      a_q <= a;
      b_q <= b;
      c_q <= carry_in;
      k   <= '0;
    end else if (state == ADD) begin
      sum[4*k +: 4] <= nib[3:0];
      c_q           <= nib[4];
      k             <= k + 1'b1;
      if (last) carry_out <= nib[4];
    end
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
  // low3[3] is the carry into the nibble's MSB; on the top nibble that is bit W-1
  logic [3:0] low3;
  assign low3 = {1'b0, a_q[4*k +: 3]} + {1'b0, b_q[4*k +: 3]} + {3'd0, c_q};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                   overflow <= 1'b0;
    else if (state == ADD && last) overflow <= low3[3] ^ nib[4];
`else
  assign overflow = 1'b0;
`endif
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: self-checking bench for nibble_serial_adder against an arithmetic model.
module tb_nibble_serial_adder;
  localparam int N = 4;
  localparam int W = 4 * N;
  logic clk, rst_n, in_valid, in_ready, carry_in, out_valid, out_ready, carry_out, overflow;
  logic [W-1:0] a, b, sum;
  int checks = 0;
  int errors = 0;
  logic [W-1:0] m_sum;
  logic m_cout, m_ov;

  nibble_serial_adder #(.NIBBLES(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .carry_in(carry_in), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry_out(carry_out), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one full transaction and checks every ADD cycle, the DONE hold and the handoff.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                        input bit hold, input int stall);
    logic [W:0] full;
    logic [63:0] mask;
    logic exp_ov;
    full = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tc};
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
    exp_ov = (ta[W-1] == tb[W-1]) && (full[W-1] != ta[W-1]);
`else
    exp_ov = 1'b0;
`endif
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);
    chk("idle_out_valid", out_valid, 0);
    in_valid = 1; a = ta; b = tb; carry_in = tc;
    @(posedge clk);
    @(negedge clk);
    if (hold) begin a = W'($urandom); b = W'($urandom); carry_in = 1'($urandom); end
    else in_valid = 0;
    for (int i = 1; i <= N; i++) begin
      @(posedge clk);
      @(negedge clk);
      mask = (64'd1 << (4 * i)) - 64'd1;
      chk($sformatf("out_valid_edge%0d", i), out_valid, i == N);
      chk($sformatf("partial_sum_edge%0d", i), sum,
          (64'(full[W-1:0]) & mask) | (64'(m_sum) & ~mask));
      if (i < N) begin
        chk("in_ready_add", in_ready, 0);
        chk("cout_held_add", carry_out, m_cout);
        chk("ov_held_add", overflow, m_ov);
      end
      if (hold) begin a = W'($urandom); b = W'($urandom); carry_in = 1'($urandom); end
    end
    chk("sum", sum, full[W-1:0]);
    chk("carry_out", carry_out, full[W]);
    chk("overflow", overflow, exp_ov);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_sum", sum, full[W-1:0]);
      chk("stall_cout", carry_out, full[W]);
      chk("stall_ov", overflow, exp_ov);
    end
    out_ready = 1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 0;
    chk("handoff_out_valid", out_valid, 0);
    chk("handoff_in_ready", in_ready, 1);
    chk("idle_sum_kept", sum, full[W-1:0]);
    in_valid = 0;
    m_sum = full[W-1:0]; m_cout = full[W]; m_ov = exp_ov;
  endtask

  initial begin
    rst_n = 0; in_valid = 0; out_ready = 0; a = '0; b = '0; carry_in = 0;
    m_sum = '0; m_cout = 0; m_ov = 0;
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", carry_out, 0);
    chk("rst_ov", overflow, 0);
    @(negedge clk);
    rst_n = 1;
    run_op(16'h0000, 16'h0000, 0, 0, 0);
    run_op(16'hFFFF, 16'h0001, 0, 0, 1);
    run_op(16'h7FFF, 16'h0001, 0, 0, 0);
    run_op(16'h0001, 16'h0001, 1, 0, 3);
    // reset during the second ADD cycle
    @(negedge clk);
    in_valid = 1; a = 16'h1234; b = 16'h4321; carry_in = 1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_sum", sum, 0);
    chk("midrst_cout", carry_out, 0);
    m_sum = '0; m_cout = 0; m_ov = 0;
    @(negedge clk);
    rst_n = 1;
    run_op(16'h0003, 16'h0006, 0, 0, 0);
    run_op(16'h8000, 16'h8000, 1, 1, 2);
    for (int r = 0; r < 10; r++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 SHALL provide parameter: NIBBLES, default 4, number of 4-bit slices; operand width W = 4*NIBBLES; legal range 1..16.
REQ-002 SHALL provide ports exactly as follows, one per line:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand set presented.
- in_ready  output  1  block can accept an operand set.
- a  input  W  operand A, unsigned or two's complement.
- b  input  W  operand B.
- carry_in  input  1  carry into nibble 0.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts result.
- sum  output  W  registered sum.
- carry_out  output  1  carry out of the top nibble.
- overflow  output  1  signed overflow flag (see Configuration).

Function
REQ-003 SHALL implement states IDLE, ADD, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-004 SHALL accept an operand set on a rising edge with in_valid=1 and in_ready=1: latch a, b, carry_in into internal registers; clear nibble index to 0; go to ADD.
REQ-005 SHALL, in ADD, each cycle add nibble k of A, nibble k of B and the stored carry with a 4-bit add; write the 4-bit result into sum[4k+3:4k]; store the nibble carry; increment k, LSB nibble first.
REQ-006 SHALL go from ADD to DONE on the edge that processes nibble NIBBLES-1; out_valid rises exactly NIBBLES rising edges after the acceptance edge.
REQ-007 SHALL set carry_out to the carry from nibble NIBBLES-1 on that same edge.
REQ-008 SHALL hold sum, carry_out and overflow stable in DONE while out_ready=0, with no cycle limit.
REQ-009 SHALL go to IDLE on a rising edge with out_valid=1 and out_ready=1; in_ready is 1 in the following cycle. No operand set is accepted in the same cycle as result handoff.
REQ-010 SHALL ignore in_valid, a, b and carry_in outside IDLE; latched operands stay unaffected by input changes after acceptance.
REQ-011 SHALL keep sum, carry_out and overflow at their last result values in IDLE and ADD; only the current nibble field of sum changes per ADD cycle.
REQ-012 SHALL wrap the sum modulo 2^W; carry_out carries the bit W of a+b+carry_in.

Reset
REQ-013 SHALL, while rst_n=0 and independent of clk, force state to IDLE, k to 0, and sum, carry_out, overflow, internal carry and operand registers to 0.
REQ-014 SHALL set outputs in reset to: in_ready=1, out_valid=0, sum=0, carry_out=0, overflow=0.
REQ-015 SHALL discard any operation in ADD or DONE when reset asserts mid-operation; no partial result is ever presented.
REQ-016 SHALL honour the first in_valid on the first rising edge after rst_n deasserts.

Configuration
REQ-017 SHALL use macro NIBBLE_SERIAL_ADDER_OVERFLOW_EN to compile the overflow detector in or out.
- Defined: on the final ADD edge, overflow = carry into bit W-1 XOR carry out of bit W-1.
- Undefined: the overflow port SHALL exist and SHALL be constant 0, with no overflow logic.

Verification
REQ-018 SHALL cover: 0x0000+0x0000, carry_in=0 -> sum=0x0000, carry_out=0; out_valid high exactly 4 edges after acceptance (NIBBLES=4).
REQ-019 SHALL cover: 0xFFFF+0x0001, carry_in=0 -> sum=0x0000, carry_out=1, overflow=0; the carry ripples through all four nibbles.
REQ-020 SHALL cover: 0x7FFF+0x0001, carry_in=0 -> sum=0x8000, carry_out=0; overflow=1 with the macro defined, 0 without.
REQ-021 SHALL cover: 0x0001+0x0001, carry_in=1 -> sum=0x0003; then hold out_ready=0 for 3 cycles -> outputs stable, in_ready=0; then out_ready=1 -> in_ready=1 the next cycle.
REQ-022 SHALL cover: reset pulse during the second ADD cycle -> out_valid=0 and in_ready=1 at once; then 0x0003+0x0006, carry_in=0 -> sum=0x0009, carry_out=0.
REQ-023 SHALL cover: in_valid held high with changing a/b during ADD and DONE -> result unaffected; the next operand set is accepted only in IDLE.
